// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: round-robin two-port cache-line memory controller with fixed grant-to-response latency
module line_mem_ctrl #(
    parameter int MEM_SIZE    = 4096,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_BYTES  = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    i_rd_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]   i_req_address_i,
    output logic                    i_gnt_o,
    output logic                    i_rvalid_o,
    output logic [LINE_BYTES*8-1:0] i_line_data_o,
    input  logic                    d_rd_req_valid_i,
    input  logic                    d_wr_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]   d_req_address_i,
    input  logic [LINE_BYTES*8-1:0] d_wr_line_data_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [LINE_BYTES*8-1:0] d_line_data_o,
    output logic                    d_write_done_o,
    output logic                    busy_o
);
    localparam int LW = LINE_BYTES * 8;
    localparam int OFF = $clog2(LINE_BYTES);
    localparam int LINES = MEM_SIZE / LINE_BYTES;
    localparam int IW = LINES > 1 ? $clog2(LINES) : 1;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LINES_A = ADDR_WIDTH'(LINES);
    localparam logic [CW-1:0] LOAD = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ptr_d, ptr_d_n;
    logic          port_d, port_d_n;
    logic          op_wr, op_wr_n;
    logic [IW-1:0] idx, idx_n;
    logic [IW-1:0] i_idx, d_idx;
    logic          i_cand, d_cand, win_d, grant, resp;
    logic [LW-1:0] rd_line;
    logic [LW-1:0] mem [LINES];

    // out-of-range addresses wrap onto the backing store
    assign i_idx = IW'((i_req_address_i >> OFF) % LINES_A);
    assign d_idx = IW'((d_req_address_i >> OFF) % LINES_A);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr_d  <= 1'b1;
            port_d <= 1'b0;
            op_wr  <= 1'b0;
            idx    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ptr_d  <= ptr_d_n;
            port_d <= port_d_n;
            op_wr  <= op_wr_n;
            idx    <= idx_n;
        end
    end

    // writes commit at the grant edge so later reads of the line see them
    always_ff @(posedge clk_i) begin
        if (grant && win_d && d_wr_req_valid_i)
            mem[d_idx] <= d_wr_line_data_i;
    end

    always_comb begin
        i_cand   = i_rd_req_valid_i;
        d_cand   = d_rd_req_valid_i || d_wr_req_valid_i;
        win_d    = d_cand && (!i_cand || ptr_d);
        grant    = rst_i && state == IDLE && (i_cand || d_cand);
        state_n  = state;
        cnt_n    = cnt;
        ptr_d_n  = ptr_d;
        port_d_n = port_d;
        op_wr_n  = op_wr;
        idx_n    = idx;
        if (grant) begin
            state_n  = MEM_LATENCY == 1 ? RESP : BUSY;
            cnt_n    = LOAD;
            ptr_d_n  = (i_cand && d_cand) ? !win_d : ptr_d;
            port_d_n = win_d;
            op_wr_n  = win_d && d_wr_req_valid_i;
            idx_n    = win_d ? d_idx : i_idx;
        end else if (state == BUSY) begin
            cnt_n   = cnt - CW'(1);
            state_n = cnt == CW'(1) ? RESP : BUSY;
        end else if (state == RESP) begin
            state_n = IDLE;
        end
        resp           = state == RESP;
        rd_line        = mem[idx];
        i_gnt_o        = grant && !win_d;
        d_gnt_o        = grant && win_d;
        i_rvalid_o     = resp && !port_d;
        d_rvalid_o     = resp && port_d && !op_wr;
        d_write_done_o = resp && port_d && op_wr;
        i_line_data_o  = i_rvalid_o ? rd_line : '0;
        d_line_data_o  = d_rvalid_o ? rd_line : '0;
        busy_o         = state != IDLE;
    end
endmodule

// File: doc/line_mem_ctrl.md
Name: line_mem_ctrl

Overview:
- Main-memory controller directly downstream of the data cache in the memory stage. It also serves the instruction cache.
- Accepts whole-cache-line read and write requests from two clients: an I-port (read-only) and a D-port (read/write).
- Arbitrates between the two clients round-robin and services one request at a time with a fixed latency.
- Returns the response on that client's port: read data with `rvalid`, or a `write_done` pulse.

Parameters:
- MEM_SIZE, params_pkg::MEM_SIZE: backing store size in bytes; must be a multiple of LINE_BYTES.
- ADDR_WIDTH, params_pkg::ADDR_WIDTH: physical request address width.
- LINE_BYTES, 16: cache line size in bytes; power of two.
- MEM_LATENCY, 4: cycles from grant to response; minimum 1.

Ports:
- clk_i, input, 1: clock; everything is on the rising edge.
- rst_i, input, 1: reset, synchronous, active-low.
- i_rd_req_valid_i, input, 1: I-port line read request.
- i_req_address_i, input, ADDR_WIDTH: I-port byte address.
- i_gnt_o, output, 1: I-port request accepted this cycle.
- i_rvalid_o, output, 1: I-port read data valid.
- i_line_data_o, output, LINE_BYTES*8: I-port read line.
- d_rd_req_valid_i, input, 1: D-port line read request.
- d_wr_req_valid_i, input, 1: D-port line write request.
- d_req_address_i, input, ADDR_WIDTH: D-port byte address.
- d_wr_line_data_i, input, LINE_BYTES*8: D-port write line.
- d_gnt_o, output, 1: D-port request accepted this cycle.
- d_rvalid_o, output, 1: D-port read data valid.
- d_line_data_o, output, LINE_BYTES*8: D-port read line.
- d_write_done_o, output, 1: D-port write completed.
- busy_o, output, 1: a request is in flight.

Behaviour:
- **Reset** (rst_i=0 at a clock edge):
  - state=IDLE, counter=0, priority pointer=D.
  - All outputs are 0.
  - The memory array is NOT cleared.
  - An in-flight request is dropped with no response. A write already committed at its grant stays written.
- **Addressing:**
  - line index = address[ADDR_WIDTH-1:log2(LINE_BYTES)] modulo (MEM_SIZE/LINE_BYTES). Out-of-range addresses wrap.
  - Offset bits are ignored.
  - Little-endian: byte 0 of the line sits in data bits [7:0].
- **States:** IDLE, BUSY, RESP.
- **IDLE:**
  - Candidates are the I-port when i_rd_req_valid_i=1, and the D-port when d_rd_req_valid_i or d_wr_req_valid_i is 1.
  - If both are candidates, the port named by the priority pointer wins. The pointer then flips to the other port.
  - If only one is a candidate, it wins and the pointer is unchanged.
  - The winner's gnt_o is driven combinationally high in the same cycle.
  - On the edge, latch port, op and line index; load counter=MEM_LATENCY-1.
  - If the D-port write is the winner, commit d_wr_line_data_i to the array at that edge.
  - Go to RESP if MEM_LATENCY==1, otherwise BUSY.
  - If d_wr and d_rd are both high, the request is treated as a write.
- **BUSY:**
  - busy_o=1. Counter decrements by 1 each cycle.
  - When counter==1, go to RESP on the next edge.
  - gnt_o is never asserted. Requests presented now are not accepted; requesters keep valid high until they get gnt.
- **RESP:** lasts one cycle, with busy_o=1.
  - For a read, assert the latched port's rvalid_o and drive its line_data_o from the array at the latched index. A same-line write accepted earlier is already visible.
  - For a write, assert d_write_done_o.
  - Return to IDLE.
  - No grant is given in the RESP cycle. The earliest next grant is the cycle after RESP.
- **Timing:** a response is asserted exactly MEM_LATENCY cycles after the grant cycle. Back-to-back throughput is 1 request per MEM_LATENCY+1 cycles.
- **Non-response cycles:** line_data_o is 0 whenever rvalid_o=0. All rvalid_o, write_done_o and gnt_o signals are single-cycle pulses.
- **Request withdrawal:** dropping valid after grant does not cancel the request.

Test Plan:
- Reset, then D-write of line 0xA5A5...A5 to addr 0x40 with MEM_LATENCY=4:
  - d_gnt_o=1 in cycle T.
  - d_write_done_o=1 only in T+4.
  - busy_o=1 for T+1..T+4.
  - The I-port sees nothing.
- D-read addr 0x4C after the above:
  - d_gnt_o in T.
  - d_rvalid_o in T+4 with d_line_data_o=0xA5..A5 (offset ignored).
  - d_line_data_o=0 in T+5.
- I-read and D-read asserted simultaneously and both held, pointer=D after reset:
  - D is granted first.
  - I is granted in the cycle after D's RESP, i.e. T+5.
  - Repeat with both held: I now wins, then D.
- Address MEM_SIZE+0x40:
  - Read returns the same data as addr 0x40.
  - Write to MEM_SIZE+0x80 is visible on a read of 0x80.
- Reset asserted in a BUSY cycle of a D-write:
  - No d_write_done_o.
  - All outputs are 0 the cycle after reset.
  - A subsequent read of that line returns the new data.
- MEM_LATENCY=1:
  - Grant in T, response in T+1.
  - Requests held continuously receive grants at T, T+2, T+4.
